// File: rtl/afg_pkg.sv
// Shared definitions for the arbitrary-function-generator waveform read path.
package afg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // A zero step would freeze the address, so it is replaced by this value.
  localparam int unsigned STEP_ZERO_SUB = 1;

endpackage

// File: rtl/burst_cfg_regs.sv
// Enable-loaded burst configuration registers (start, end, step, pass count),
// each with its own reset value.
module burst_cfg_regs #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] ld_start,
  input  logic [ADDR_W-1:0] ld_end,
  input  logic [ADDR_W-1:0] ld_step,
  input  logic [CNT_W-1:0]  ld_count,
  output logic [ADDR_W-1:0] cfg_start,
  output logic [ADDR_W-1:0] cfg_end,
  output logic [ADDR_W-1:0] cfg_step,
  output logic [CNT_W-1:0]  cfg_count
);
  import afg_pkg::*;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      cfg_start <= '0;
      cfg_end   <= '0;
      cfg_step  <= ADDR_W'(STEP_ZERO_SUB);
      cfg_count <= '0;
    end else if (load) begin
      cfg_start <= ld_start;
      cfg_end   <= ld_end;
      cfg_step  <= (ld_step == '0) ? ADDR_W'(STEP_ZERO_SUB) : ld_step;
      cfg_count <= ld_count;
    end
  end

endmodule

// File: rtl/burst_addr_gen.sv
// Burst address generator: steps the waveform RAM read address from start to
// end on each sample tick, wrapping per pass and stopping after N passes.
module burst_addr_gen #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_start,
  input  logic [ADDR_W-1:0] ld_end,
  input  logic [ADDR_W-1:0] ld_step,
  input  logic [CNT_W-1:0]  ld_count,
  input  logic              start,
  input  logic              stop,
  input  logic              tick,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  passes_left
);
  import afg_pkg::*;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [CNT_W-1:0]    passes_nxt;
  logic [ADDR_W-1:0]   cfg_start, cfg_end, cfg_step;
  logic [CNT_W-1:0]    cfg_count;
  logic [ADDR_W:0]     sum;
  logic                cfg_load;

  assign cfg_load = ld_en && (state == IDLE);

  burst_cfg_regs #(
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) u_cfg (
    .Clock    (Clock),
    .Reset    (Reset),
    .load     (cfg_load),
    .ld_start (ld_start),
    .ld_end   (ld_end),
    .ld_step  (ld_step),
    .ld_count (ld_count),
    .cfg_start(cfg_start),
    .cfg_end  (cfg_end),
    .cfg_step (cfg_step),
    .cfg_count(cfg_count)
  );

  // One extra bit keeps the carry so an overflowing step ends the pass.
  assign sum = {1'b0, addr} + {1'b0, cfg_step};

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state       <= IDLE;
      addr        <= '0;
      passes_left <= '0;
    end else begin
      state       <= state_nxt;
      addr        <= addr_nxt;
      passes_left <= passes_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    addr_nxt   = addr;
    passes_nxt = passes_left;
    busy       = 1'b0;
    addr_valid = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        // A same-cycle load feeds the burst directly, bypassing the registers.
        if (start && !stop) begin
          state_nxt  = RUN;
          addr_nxt   = ld_en ? ld_start : cfg_start;
          passes_nxt = ld_en ? ld_count : cfg_count;
        end
      end
      RUN: begin
        busy       = 1'b1;
        addr_valid = 1'b1;
        if (stop) begin
          state_nxt = IDLE;
        end else if (tick) begin
          if (sum > {1'b0, cfg_end}) begin
            addr_nxt = cfg_start;
            if (cfg_count != '0) begin
              if (passes_left == CNT_W'(1)) begin
                passes_nxt = '0;
                state_nxt  = FIN;
              end else begin
                passes_nxt = passes_left - CNT_W'(1);
              end
            end
          end else begin
            addr_nxt = sum[ADDR_W-1:0];
          end
        end
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
